// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for a big-endian 4-byte-wide memory.
// Define ALIGN_CHECK_EN to add addr_err and skip memory on misaligned requests.
module mem_access_unit #(
  parameter int RD_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        busy,
`ifdef ALIGN_CHECK_EN
  output logic        addr_err,
`endif
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_data
);

  localparam int CW = $clog2(RD_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [1:0]    size_q;
  logic          signed_q;
  logic          write_q;
  logic [15:0]   wdata_q;
  logic          accept;
  logic          is_word;
  logic          cnt_done;
  logic          misal;
  logic [31:0]   ld_data;
  logic [31:0]   st_data;

  assign accept     = req_valid & req_ready;
  assign is_word    = req_size[1];
  assign cnt_done   = (cnt == '0);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

`ifdef ALIGN_CHECK_EN
  assign misal = ((req_size == 2'b01) && req_addr[0]) ||
                 (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    ld_data = mem_data;
    unique case (1'b1)
      size_q == 2'b00:
        ld_data = {{24{signed_q & mem_data[31]}}, mem_data[31:24]};
      size_q == 2'b01:
        ld_data = {{16{signed_q & mem_data[31]}}, mem_data[31:16]};
      default:
        ld_data = mem_data;
    endcase
  end

  // sub-word store: new bytes land at A (and A+1), rest is read back
  always_comb begin
    st_data = {wdata_q, mem_data[15:0]};
    if (size_q == 2'b00)
      st_data = {wdata_q[7:0], mem_data[23:0]};
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (misal)
            state_nx = RESP;
          else if (req_write && is_word)
            state_nx = WRITE;
          else
            state_nx = READ;
        end
      end
      READ:    if (cnt_done) state_nx = write_q ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      size_q         <= '0;
      signed_q       <= 1'b0;
      write_q        <= 1'b0;
      wdata_q        <= '0;
      resp_rdata     <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
`ifdef ALIGN_CHECK_EN
      addr_err       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            mem_address <= req_addr;
            size_q      <= req_size;
            signed_q    <= req_signed;
            write_q     <= req_write;
            wdata_q     <= req_wdata[15:0];
`ifdef ALIGN_CHECK_EN
            addr_err    <= misal;
`endif
            if (!misal) begin
              if (req_write && is_word) begin
                mem_write      <= 1'b1;
                mem_write_data <= req_wdata;
              end else begin
                mem_read <= 1'b1;
                cnt      <= CW'(RD_WAIT - 1);
              end
            end
          end
        end
        READ: begin
          if (cnt_done) begin
            mem_read <= 1'b0;
            if (write_q) begin
              mem_write      <= 1'b1;
              mem_write_data <= st_data;
            end else begin
              resp_rdata <= ld_data;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WRITE: mem_write <= 1'b0;
        RESP: begin
`ifdef ALIGN_CHECK_EN
          addr_err <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a big-endian byte memory.
// Build with ALIGN_CHECK_EN to exercise the addr_err path.
module tb_mem_access_unit;

  localparam int RDW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        busy;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_data = '0;
`ifdef ALIGN_CHECK_EN
  logic        addr_err;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] last_ld = '0;
  bit          mon_en = 1'b0;
  logic [7:0]  m  [256];
  logic [7:0]  sm [256];
  logic [7:0]  ma;

  mem_access_unit #(.RD_WAIT(RDW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .busy           (busy),
`ifdef ALIGN_CHECK_EN
    .addr_err       (addr_err),
`endif
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_data       (mem_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign ma = mem_address[7:0];

  // memory: one-cycle read delay, commits a word when mem_write is sampled
  always @(posedge clk) begin
    if (mem_write) begin
      m[ma]       <= mem_write_data[31:24];
      m[ma+8'd1]  <= mem_write_data[23:16];
      m[ma+8'd2]  <= mem_write_data[15:8];
      m[ma+8'd3]  <= mem_write_data[7:0];
    end
    mem_data <= {m[ma], m[ma+8'd1], m[ma+8'd2], m[ma+8'd3]};
  end

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit hold);
    exp_t       e;
    int         n;
    logic       mis;
    logic [7:0] ix;
    logic [7:0] b0, b1, b2, b3;
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) begin
      chk("accept_to", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    chk("gap", 32'(q.size()), 32'd0);
    ix = a[7:0];
    b0 = sm[ix];
    b1 = sm[ix+8'd1];
    b2 = sm[ix+8'd2];
    b3 = sm[ix+8'd3];
`ifdef ALIGN_CHECK_EN
    mis = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    e.err = mis;
    e.acc = cyc;
    if (mis) begin
      e.lat = 1;
      e.nrd = 0;
      e.nwr = 0;
    end else if (!w) begin
      e.lat = RDW + 1;
      e.nrd = RDW;
      e.nwr = 0;
      if (sz == 2'b00)
        last_ld = {{24{sg & b0[7]}}, b0};
      else if (sz == 2'b01)
        last_ld = {{16{sg & b0[7]}}, b0, b1};
      else
        last_ld = {b0, b1, b2, b3};
    end else if (sz[1]) begin
      e.lat = 2;
      e.nrd = 0;
      e.nwr = 1;
      sm[ix]       = wd[31:24];
      sm[ix+8'd1]  = wd[23:16];
      sm[ix+8'd2]  = wd[15:8];
      sm[ix+8'd3]  = wd[7:0];
    end else begin
      e.lat = RDW + 2;
      e.nrd = RDW;
      e.nwr = 1;
      if (sz == 2'b00) begin
        sm[ix] = wd[7:0];
      end else begin
        sm[ix]      = wd[15:8];
        sm[ix+8'd1] = wd[7:0];
      end
    end
    e.rdata = last_ld;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || busy)
      chk("drain_to", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    int   nrd;
    int   nwr;
    nrd = 0;
    nwr = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        nrd = 0;
        nwr = 0;
      end else begin
        chk("rw_excl", 32'(mem_read & mem_write), 32'd0);
        if (mem_read)  nrd++;
        if (mem_write) nwr++;
        if (resp_valid) begin
          if (q.size() == 0) begin
            chk("spurious_resp", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            chk("rdata", resp_rdata, e.rdata);
            chk("rd_cycles", 32'(nrd), 32'(e.nrd));
            chk("wr_cycles", 32'(nwr), 32'(e.nwr));
            chk("busy_resp", 32'(busy), 32'd1);
`ifdef ALIGN_CHECK_EN
            chk("addr_err", 32'(addr_err), 32'(e.err));
`endif
          end
          nrd = 0;
          nwr = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    int diffs;
    for (int i = 0; i < 256; i++) begin
      m[i]  <= 8'(i);
      sm[i]  = 8'(i);
    end
    m[8'h20] <= 8'h80; m[8'h21] <= 8'h7F; m[8'h22] <= 8'h12; m[8'h23] <= 8'h34;
    m[8'h30] <= 8'h11; m[8'h31] <= 8'h22; m[8'h32] <= 8'h33; m[8'h33] <= 8'h44;
    sm[8'h20] = 8'h80; sm[8'h21] = 8'h7F; sm[8'h22] = 8'h12; sm[8'h23] = 8'h34;
    sm[8'h30] = 8'h11; sm[8'h31] = 8'h22; sm[8'h32] = 8'h33; sm[8'h33] = 8'h44;

    #3;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
`ifdef ALIGN_CHECK_EN
    chk("rst_addr_err", 32'(addr_err), 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    // reset while a sub-word store is still reading
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h30;
    req_wdata = 32'hEE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("abort_rd_before", 32'(mem_read), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_read", 32'(mem_read), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_mem", {m[8'h30], m[8'h31], m[8'h32], m[8'h33]}, 32'h11223344);
    mon_en = 1'b1;

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    drain();
    chk("sw_mem", {m[8'h10], m[8'h11], m[8'h12], m[8'h13]}, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    drain();
    chk("lw", resp_rdata, 32'hDEADBEEF);

    issue(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 1'b0);
    drain();
    chk("lb", resp_rdata, 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0);
    drain();
    chk("lbu", resp_rdata, 32'h00000080);
    issue(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0);
    drain();
    chk("lh", resp_rdata, 32'hFFFF807F);
    issue(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b0);
    drain();
    chk("lhu", resp_rdata, 32'h0000807F);

    issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h123456AB, 1'b0);
    drain();
    chk("sb_mem", {m[8'h20], m[8'h21], m[8'h22], m[8'h23]}, 32'hAB7F1234);
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF5566, 1'b0);
    drain();
    chk("sh_mem", {m[8'h20], m[8'h21], m[8'h22], m[8'h23]}, 32'hAB7F5566);
    chk("sh_nbr", {16'd0, m[8'h24], m[8'h25]}, 32'h00002425);

    // back-to-back with req_valid held high
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h01020304, 1'b1);
    issue(1'b1, 2'b00, 1'b0, 32'h41, 32'h00000099, 1'b1);
    issue(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 1'b1);
    issue(1'b1, 2'b11, 1'b0, 32'h44, 32'hCAFEF00D, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'h44, 32'h0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
    drain();
    chk("b2b_lw", resp_rdata, 32'h01990304);

    // unaligned: as-is by default, rejected with addr_err when checked
    issue(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b0);
    drain();
    issue(1'b0, 2'b01, 1'b1, 32'h21, 32'h0, 1'b0);
    drain();
    issue(1'b1, 2'b01, 1'b0, 32'h23, 32'h0000A5A5, 1'b0);
    drain();
    issue(1'b1, 2'b10, 1'b0, 32'h46, 32'h5A5A5A5A, 1'b0);
    drain();

    repeat (2) @(posedge clk);
    #1;
    diffs = 0;
    for (int i = 0; i < 256; i++)
      if (m[i] !== sm[i]) diffs++;
    chk("mem_final", 32'(diffs), 32'd0);
    chk("end_ready", 32'(req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
